note_hit_judge: RTL and testbench

- Per-lane hit judge that sits directly downstream of each falling-note sprite (one instance per colour lane).
- Consumes the sprite's Y position and an active flag, plus the lane's key-press bit decoded from the keyboard keycode.
- Decides hit, miss or ghost press once per note, and keeps a saturating score and combo streak.
- Top level sums the lane scores and drives the display overlay from the pulses.

---
 rtl/guitar_pkg.sv | 14 +
 rtl/note_hit_judge_rise_detect.sv | 44 ++++
 rtl/note_hit_judge.sv | 152 +++++++++++++++
 tb/tb_note_hit_judge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/guitar_pkg.sv
// Shared types and widths for the per-lane note hit judge.
package guitar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        JUDGED = 2'd2
    } judge_state_t;

    localparam int SCORE_W     = 16;
    localparam int STREAK_W    = 8;
    localparam int PERFECT_TOL = 4;

endpackage

// File: rtl/note_hit_judge_rise_detect.sv
// Registered rising-edge detector with an optional 2-flop input synchroniser.
module rise_detect #(
    parameter bit SYNC_EN = 1'b1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic rise
);

    logic level;
    logic prev_p2;

    generate
        if (SYNC_EN) begin : g_sync
            logic sync_p0;
            logic sync_p1;
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    sync_p0 <= 1'b0;
                    sync_p1 <= 1'b0;
                end else begin
                    sync_p0 <= sig;
                    sync_p1 <= sync_p0;
                end
            end
            assign level = sync_p1;
        end else begin : g_bypass
            assign level = sig;
        end
    endgenerate

    // edge stage: rise is registered, so it trails level by one cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_p2 <= 1'b0;
            rise    <= 1'b0;
        end else begin
            prev_p2 <= level;
            rise    <= level & ~prev_p2;
        end
    end

endmodule

// File: rtl/note_hit_judge.sv
// Per-lane hit/miss/ghost judge with saturating score and combo streak.
// Optional macro JUDGE_PERFECT_EN adds perfect_pulse and double points near zone centre.
module note_hit_judge
    import guitar_pkg::*;
#(
    parameter logic [9:0]  HIT_Y_MIN   = 10'd400,
    parameter logic [9:0]  HIT_Y_MAX   = 10'd440,
    parameter logic [15:0] POINTS      = 16'd10,
    parameter logic [7:0]  STREAK_STEP = 8'd8,
    parameter logic [2:0]  MULT_MAX    = 3'd4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                key_pressed,
    input  logic [9:0]          note_y_pos,
    input  logic                note_active,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic                ghost_pulse,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [1:0]          judge_state
`ifdef JUDGE_PERFECT_EN
    ,
    output logic                perfect_pulse
`endif
);

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] acc,
                                                     input logic [SCORE_W:0]   inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, acc} + inc;
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    function automatic logic [STREAK_W-1:0] sat_streak(input logic [STREAK_W-1:0] s);
        return (s == {STREAK_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    judge_state_t        state, state_nxt;
    logic                key_rise, frame_rise, active_q;
    logic                hit_nxt, miss_nxt, ghost_nxt;
    logic [SCORE_W-1:0]  score_nxt;
    logic [STREAK_W-1:0] streak_nxt;
    logic                in_zone, active_fall;
    logic [STREAK_W-1:0] step_idx;
    logic [STREAK_W:0]   mult_raw;
    logic [2:0]          mult;
    logic [SCORE_W:0]    hit_pts, award;

    rise_detect #(.SYNC_EN(1'b1)) u_key_rise (
        .Clk(Clk), .Reset(Reset), .sig(key_pressed), .rise(key_rise)
    );

    rise_detect #(.SYNC_EN(1'b0)) u_frame_rise (
        .Clk(Clk), .Reset(Reset), .sig(frame_clk), .rise(frame_rise)
    );

    assign in_zone     = (note_y_pos >= HIT_Y_MIN) && (note_y_pos <= HIT_Y_MAX);
    assign active_fall = active_q & ~note_active;

    // multiplier uses the streak before this hit is counted
    assign step_idx = streak / STREAK_STEP;
    assign mult_raw = {1'b0, step_idx} + 9'd1;
    assign mult     = (mult_raw >= {6'd0, MULT_MAX}) ? MULT_MAX : mult_raw[2:0];
    assign hit_pts  = {1'b0, POINTS} * {14'd0, mult};

`ifdef JUDGE_PERFECT_EN
    localparam logic [10:0] Y_MID = ({1'b0, HIT_Y_MIN} + {1'b0, HIT_Y_MAX}) >> 1;
    logic perfect_zone, perfect_nxt;
    assign perfect_zone = ({1'b0, note_y_pos} >= Y_MID - 11'(PERFECT_TOL)) &&
                          ({1'b0, note_y_pos} <= Y_MID + 11'(PERFECT_TOL));
    assign award = perfect_zone ? {hit_pts[SCORE_W-1:0], 1'b0} : hit_pts;
`else
    assign award = hit_pts;
`endif

    always_comb begin
        state_nxt  = state;
        score_nxt  = score;
        streak_nxt = streak;
        hit_nxt    = 1'b0;
        miss_nxt   = 1'b0;
        ghost_nxt  = 1'b0;
`ifdef JUDGE_PERFECT_EN
        perfect_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                // a note already inside the zone is never armed
                if (note_active && (note_y_pos < HIT_Y_MIN)) state_nxt = ARMED;
                if (key_rise) ghost_nxt = 1'b1;
            end
            ARMED: begin
                if (key_rise && in_zone) begin
                    hit_nxt    = 1'b1;
                    score_nxt  = sat_score(score, award);
                    streak_nxt = sat_streak(streak);
                    state_nxt  = JUDGED;
`ifdef JUDGE_PERFECT_EN
                    perfect_nxt = perfect_zone;
`endif
                end else begin
                    if (key_rise) begin
                        ghost_nxt  = 1'b1;
                        streak_nxt = '0;
                    end
                    if ((frame_rise && (note_y_pos > HIT_Y_MAX)) || active_fall) begin
                        miss_nxt   = 1'b1;
                        streak_nxt = '0;
                        state_nxt  = JUDGED;
                    end
                end
            end
            JUDGED: begin
                if (!note_active) state_nxt = IDLE;
                if (key_rise) ghost_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            score       <= '0;
            streak      <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            ghost_pulse <= 1'b0;
            active_q    <= 1'b0;
`ifdef JUDGE_PERFECT_EN
            perfect_pulse <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            score       <= score_nxt;
            streak      <= streak_nxt;
            hit_pulse   <= hit_nxt;
            miss_pulse  <= miss_nxt;
            ghost_pulse <= ghost_nxt;
            active_q    <= note_active;
`ifdef JUDGE_PERFECT_EN
            perfect_pulse <= perfect_nxt;
`endif
        end
    end

    assign judge_state = state;

endmodule

// File: tb/tb_note_hit_judge.sv
// Self-checking bench for note_hit_judge: directed scenarios plus randomized play against a rule-level model.
module tb_note_hit_judge;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       key_pressed = 1'b0;
    logic [9:0] note_y_pos = 10'd0;
    logic       note_active = 1'b0;
    logic       hit_pulse, miss_pulse, ghost_pulse;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [1:0]  judge_state;
    wire         perf_bit;

`ifdef JUDGE_PERFECT_EN
    logic perfect_pulse;
    assign perf_bit = perfect_pulse;
    localparam int PM = 2;
`else
    assign perf_bit = 1'b0;
    localparam int PM = 1;
`endif

    note_hit_judge dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .key_pressed(key_pressed),
        .note_y_pos(note_y_pos), .note_active(note_active),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .ghost_pulse(ghost_pulse),
        .score(score), .streak(streak), .judge_state(judge_state)
`ifdef JUDGE_PERFECT_EN
        , .perfect_pulse(perfect_pulse)
`endif
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_fail = 0;

    // rule-level model: states 0 idle, 1 armed, 2 judged; raw input history per edge
    int m_state = 0, m_score = 0, m_streak = 0;
    bit m_hit = 0, m_miss = 0, m_ghost = 0, m_perf = 0;
    bit kq[$] = '{0, 0, 0, 0};
    bit fq[$] = '{0, 0};
    bit na_prev = 0;

    wire [29:0] obs_v = {hit_pulse, miss_pulse, ghost_pulse, perf_bit, score, streak, judge_state};

    function automatic logic [29:0] exp_v();
        return {m_hit, m_miss, m_ghost, m_perf, 16'(m_score), 8'(m_streak), 2'(m_state)};
    endfunction

    task automatic tick();
        bit kr, fr, fall, inz, prf;
        int mult, add, nst;
        @(posedge Clk);
        if (Reset) begin
            m_state = 0; m_score = 0; m_streak = 0;
            m_hit = 0; m_miss = 0; m_ghost = 0; m_perf = 0;
            kq.push_back(1'b0); fq.push_back(1'b0); na_prev = 0;
        end else begin
            kr   = kq[kq.size()-3] && !kq[kq.size()-4];
            fr   = fq[fq.size()-1] && !fq[fq.size()-2];
            fall = na_prev && !note_active;
            inz  = (note_y_pos >= 400) && (note_y_pos <= 440);
            prf  = (PM == 2) && (note_y_pos >= 416) && (note_y_pos <= 424);
            m_hit = 0; m_miss = 0; m_ghost = 0; m_perf = 0;
            nst = m_state;
            if (m_state == 0) begin
                if (note_active && note_y_pos < 400) nst = 1;
                m_ghost = kr;
            end else if (m_state == 1) begin
                if (kr && inz) begin
                    mult = 1 + m_streak / 8;
                    if (mult > 4) mult = 4;
                    add = 10 * mult * (prf ? 2 : 1);
                    m_score = (m_score + add > 65535) ? 65535 : m_score + add;
                    m_streak = (m_streak >= 255) ? 255 : m_streak + 1;
                    m_hit = 1; m_perf = prf; nst = 2;
                end else begin
                    if (kr) begin m_ghost = 1; m_streak = 0; end
                    if ((fr && note_y_pos > 440) || fall) begin m_miss = 1; m_streak = 0; nst = 2; end
                end
            end else begin
                if (!note_active) nst = 0;
                m_ghost = kr;
            end
            m_state = nst;
            kq.push_back(key_pressed); fq.push_back(frame_clk); na_prev = note_active;
        end
        if (kq.size() > 8) void'(kq.pop_front());
        if (fq.size() > 8) void'(fq.pop_front());
        #1;
    endtask

    task automatic do_reset();
        key_pressed = 0; frame_clk = 0; note_active = 0; note_y_pos = 0;
        repeat (4) tick();
        Reset = 1;
        repeat (2) tick();
        Reset = 0;
    endtask

    // full note: arm at 300, move to yp, press, release, wrap; pv = outputs in the judgement cycle
    task automatic do_note(input int yp, output logic [29:0] pv);
        note_active = 1; note_y_pos = 10'd300; tick();
        note_y_pos = 10'(yp); tick();
        key_pressed = 1; repeat (4) tick();
        pv = obs_v;
        key_pressed = 0; tick();
        note_active = 0; note_y_pos = 0; tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", score); end
        n_checks++; if (streak !== 8'd0) begin n_fail++; $display("FAIL reset_streak got %0d want 0", streak); end
        n_checks++; if (judge_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", judge_state); end
        n_checks++; if ({hit_pulse, miss_pulse, ghost_pulse, perf_bit} !== 4'b0) begin
            n_fail++; $display("FAIL reset_pulses got %b want 0000", {hit_pulse, miss_pulse, ghost_pulse, perf_bit}); end
    endtask

    task automatic test_hit();
        note_active = 1; note_y_pos = 10'd300; tick();
        n_checks++; if (judge_state !== 2'd1) begin n_fail++; $display("FAIL hit_arm state got %0d want 1", judge_state); end
        note_y_pos = 10'd420; tick();
        key_pressed = 1; repeat (3) tick();
        n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_early got %b want 0", hit_pulse); end
        tick();
        n_checks++; if (hit_pulse !== 1'b1) begin n_fail++; $display("FAIL hit_pulse got %b want 1", hit_pulse); end
        n_checks++; if (score !== 16'(10 * PM)) begin n_fail++; $display("FAIL hit_score got %0d want %0d", score, 10 * PM); end
        n_checks++; if (streak !== 8'd1) begin n_fail++; $display("FAIL hit_streak got %0d want 1", streak); end
        n_checks++; if (judge_state !== 2'd2) begin n_fail++; $display("FAIL hit_state got %0d want 2", judge_state); end
        tick();
        n_checks++; if (hit_pulse !== 1'b0) begin n_fail++; $display("FAIL hit_width got %b want 0", hit_pulse); end
        key_pressed = 0; tick();
        note_active = 0; note_y_pos = 0; tick(); tick();
        n_checks++; if (obs_v !== exp_v()) begin n_fail++; $display("FAIL hit_model got %h want %h", obs_v, exp_v()); end
    endtask

    task automatic test_multiplier();
        logic [29:0] pv;
        do_reset();
        repeat (8) do_note(410, pv);
        n_checks++; if (score !== 16'd80 || streak !== 8'd8) begin
            n_fail++; $display("FAIL mult1 score %0d streak %0d want 80 8", score, streak); end
        do_note(410, pv);
        n_checks++; if (score !== 16'd100) begin n_fail++; $display("FAIL mult2 score got %0d want 100", score); end
        repeat (21) do_note(410, pv);
        n_checks++; if (score !== 16'd720 || streak !== 8'd30) begin
            n_fail++; $display("FAIL mult3 score %0d streak %0d want 720 30", score, streak); end
        do_note(410, pv);
        n_checks++; if (score !== 16'd760 || streak !== 8'd31) begin
            n_fail++; $display("FAIL mult_cap score %0d streak %0d want 760 31", score, streak); end
        n_checks++; if (obs_v !== exp_v()) begin n_fail++; $display("FAIL mult_model got %h want %h", obs_v, exp_v()); end
    endtask

    task automatic test_miss();
        note_active = 1; note_y_pos = 10'd300; tick();
        note_y_pos = 10'd443; tick();
        n_checks++; if (miss_pulse !== 1'b0 || judge_state !== 2'd1) begin
            n_fail++; $display("FAIL miss_noframe miss %b state %0d want 0 1", miss_pulse, judge_state); end
        frame_clk = 1; tick();
        frame_clk = 0; tick();
        n_checks++; if (miss_pulse !== 1'b1) begin n_fail++; $display("FAIL miss_pulse got %b want 1", miss_pulse); end
        n_checks++; if (score !== 16'd760 || streak !== 8'd0 || judge_state !== 2'd2) begin
            n_fail++; $display("FAIL miss_state score %0d streak %0d state %0d want 760 0 2", score, streak, judge_state); end
        tick();
        n_checks++; if (miss_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_width got %b want 0", miss_pulse); end
        note_active = 0; note_y_pos = 0; tick(); tick();
        n_checks++; if (obs_v !== exp_v()) begin n_fail++; $display("FAIL miss_model got %h want %h", obs_v, exp_v()); end
    endtask

    task automatic test_ghost();
        logic [29:0] pv;
        do_note(410, pv);
        note_active = 1; note_y_pos = 10'd300; tick();
        note_y_pos = 10'd350; tick();
        key_pressed = 1; repeat (4) tick();
        n_checks++; if (ghost_pulse !== 1'b1 || hit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL ghost_pulse ghost %b hit %b want 1 0", ghost_pulse, hit_pulse); end
        n_checks++; if (streak !== 8'd0 || judge_state !== 2'd1) begin
            n_fail++; $display("FAIL ghost_state streak %0d state %0d want 0 1", streak, judge_state); end
        key_pressed = 0; tick(); tick();
        note_y_pos = 10'd410; tick();
        key_pressed = 1; repeat (4) tick();
        n_checks++; if (hit_pulse !== 1'b1 || score !== 16'd780 || streak !== 8'd1) begin
            n_fail++; $display("FAIL ghost_rehit hit %b score %0d streak %0d want 1 780 1", hit_pulse, score, streak); end
        key_pressed = 0; tick();
        note_active = 0; note_y_pos = 0; tick(); tick();
    endtask

    task automatic test_reset_midnote();
        note_active = 1; note_y_pos = 10'd300; tick();
        note_y_pos = 10'd420; tick();
        Reset = 1; tick();
        Reset = 0;
        n_checks++; if (judge_state !== 2'd0 || score !== 16'd0 || streak !== 8'd0) begin
            n_fail++; $display("FAIL midreset state %0d score %0d streak %0d want 0 0 0", judge_state, score, streak); end
        repeat (3) tick();
        n_checks++; if (judge_state !== 2'd0) begin n_fail++; $display("FAIL midreset_rearm state %0d want 0", judge_state); end
        key_pressed = 1; repeat (4) tick();
        n_checks++; if (ghost_pulse !== 1'b1 || hit_pulse !== 1'b0 || score !== 16'd0) begin
            n_fail++; $display("FAIL idle_ghost ghost %b hit %b score %0d want 1 0 0", ghost_pulse, hit_pulse, score); end
        key_pressed = 0; note_active = 0; note_y_pos = 0; tick(); tick();
    endtask

`ifdef JUDGE_PERFECT_EN
    task automatic test_perfect();
        logic [29:0] pv;
        do_reset();
        do_note(420, pv);
        n_checks++; if (pv[29] !== 1'b1 || pv[26] !== 1'b1 || pv[25:10] !== 16'd20) begin
            n_fail++; $display("FAIL perfect hit %b perf %b score %0d want 1 1 20", pv[29], pv[26], pv[25:10]); end
        do_note(430, pv);
        n_checks++; if (pv[29] !== 1'b1 || pv[26] !== 1'b0 || pv[25:10] !== 16'd30) begin
            n_fail++; $display("FAIL nonperfect hit %b perf %b score %0d want 1 0 30", pv[29], pv[26], pv[25:10]); end
    endtask
`endif

    task automatic test_saturation();
        logic [29:0] pv;
        do_reset();
        for (int i = 0; i < 2000 && m_score < 65535; i++) begin
            do_note(420, pv);
            n_checks++; if (obs_v !== exp_v()) begin
                n_fail++; $display("FAIL sat_model note %0d got %h want %h", i, obs_v, exp_v()); end
        end
        n_checks++; if (score !== 16'hFFFF) begin n_fail++; $display("FAIL sat_score got %h want ffff", score); end
        n_checks++; if (streak !== 8'd255) begin n_fail++; $display("FAIL sat_streak got %0d want 255", streak); end
    endtask

    task automatic test_random();
        int y = 0, gap = 3;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (note_active) begin
                y = y + int'($urandom_range(0, 2));
                if (y > 470) begin note_active = 0; y = 0; gap = int'($urandom_range(2, 6)); end
            end else if (gap > 0) gap--;
            else note_active = 1;
            note_y_pos = 10'(y);
            frame_clk = ((c / 6) % 2) == 1;
            if ($urandom_range(0, 9) == 0) key_pressed = ~key_pressed;
            tick();
            n_checks++; if (obs_v !== exp_v()) begin
                n_fail++; $display("FAIL rand_cycle %0d got %h want %h", c, obs_v, exp_v()); end
        end
        key_pressed = 0; frame_clk = 0;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_multiplier();
        test_miss();
        test_ghost();
        test_reset_midnote();
`ifdef JUDGE_PERFECT_EN
        test_perfect();
`endif
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
